mdio_master_ctrl: RTL and testbench
===================================

# mdio_master_ctrl

Clause-22 MDIO management controller that sequences PHY register reads and writes over the MDC/MDIO pins of the MCU Ethernet port. It accepts one command at a time from the on-chip register interface on a valid/ready handshake and serialises it into a 64-bit management frame. It drives MDC and the MDIO output/enable, captures read data, and returns a one-cycle response strobe. It sits between the ETH peripheral register block and the MDC/MDIO pad cells.

## Interface
- CLK_DIV, 10: MDC half-period in `clk` cycles; legal range ≥2. MDC frequency = f(clk) / (2·CLK_DIV).
- clk  in  1  system clock; the only clock.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on `cmd_valid && cmd_ready`.
- cmd_read  in  1  1 = read (OP=10), 0 = write (OP=01).
- cmd_phy  in  5  PHY address.
- cmd_reg  in  5  register address.
- cmd_wdata  in  16  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse at frame end.
- rsp_rdata  out  16  read data; updated only at the end of a read and held until the next read completes.
- rsp_err  out  1  valid with `rsp_valid`; set on a read when the PHY did not drive TA bit 2 low.
- busy  out  1  equal to `!cmd_ready`.
- mdc  out  1  management clock; idles low.
- mdio_o  out  1  MDIO output data.
- mdio_oe  out  1  MDIO output enable.
- mdio_i  in  1  MDIO input from the pad.

## Operation
- The frame, MSB first, is: PRE (32 × '1'), ST=01, OP, PHYAD[4:0], REGAD[4:0], TA, DATA[15:0].
- The command fields are latched at acceptance into a 32-bit shift register holding {ST,OP,PHY,REG,TA,DATA}. For reads, the TA and DATA fields are loaded as 1.
- States:
  - IDLE → PRE on accept.
  - PRE: 32 bits → HDR.
  - HDR: 14 bits → TA.
  - TA: 2 bits → DATA.
  - DATA: 16 bits → DONE.
  - DONE: 1 cycle → IDLE.
- A bit counter (6 bits) is reloaded on each state entry.
- `mdio_oe` is 1 in PRE and HDR.
  - Write: `mdio_oe` stays 1 through TA (driving 1,0) and DATA.
  - Read: `mdio_oe` drops to 0 at the start of TA and stays 0 until IDLE.
- Read capture:
  - `mdio_i` is sampled on the last `clk` cycle of each MDC-high phase.
  - The TA bit-2 sample sets `rsp_err` if it is 1.
  - The DATA samples shift into `rsp_rdata` MSB first.
- A command presented while busy is not accepted (`cmd_ready`=0). The requester must hold `cmd_valid`.
- Reset mid-frame aborts the frame immediately. All outputs return to their reset values and no `rsp_valid` is issued.

## Timing
- Reset values:
  - cmd_ready=1, busy=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=16'h0000.
  - mdc=0, mdio_o=1, mdio_oe=0.
- Bit period is 2·CLK_DIV cycles: MDC is low for CLK_DIV cycles, then high for CLK_DIV cycles.
- `mdio_o`/`mdio_oe` change only in the cycle where `mdc` goes 1→0, or at frame start. This gives CLK_DIV cycles of setup before each rising edge.
- Cycle 1 after acceptance: state=PRE, mdio_oe=1, mdio_o=1, mdc=0, divider=0.
- `rsp_valid` asserts at cycle 128·CLK_DIV + 1 after the acceptance edge, in the DONE state.
  - `rsp_rdata`/`rsp_err` are valid in that same cycle.
  - `cmd_ready` returns to 1 in the following cycle.
- Back-to-back throughput: one command per 128·CLK_DIV + 2 cycles.

## Configuration
- Macro: `MDIO_PREAMBLE_SUPPRESS_EN`.
- Defined:
  - Adds input `cmd_nopre` (1 bit, latched with the command).
  - When 1, the PRE state is skipped: IDLE → HDR, and `rsp_valid` comes at cycle 64·CLK_DIV + 1.
  - When 0, the frame is a full frame.
- Undefined: the port is absent and the 32-bit preamble is always sent.

## Structure
- Package/header `mdio_pkg`:
  - State encodings (IDLE, PRE, HDR, TA, DATA, DONE).
  - Opcodes (OP_WR=2'b01, OP_RD=2'b10), ST=2'b01.
  - Field lengths (PRE_LEN=32, HDR_LEN=14, TA_LEN=2, DATA_LEN=16).
- Sub-module `mdio_clk_gen`:
  - CLK_DIV down-counter that toggles `mdc`.
  - Emits the one-cycle strobes `fall_stb` (mdc 1→0) and `rise_end_stb` (last high cycle).
  - Held in reset while the controller is IDLE, so mdc stays low.
- The FSM, shift register, bit counter and capture logic live in `mdio_master_ctrl`.

## Test plan
- Write, CLK_DIV=2, phy=5'h01, reg=5'h00, wdata=16'h1140:
  - The PHY bench model captures 32 ones, then 01 01 00001 00000 10 0001000101000000.
  - `rsp_valid` at cycle 257; `rsp_err`=0.
- Read, phy=5'h01, reg=5'h02, model returns 16'h0022 with TA bit 2 = 0:
  - mdio_oe=0 from TA onward.
  - rsp_rdata=16'h0022, rsp_err=0.
- Read with no PHY (mdio_i pulled to 1): rsp_rdata=16'hFFFF, rsp_err=1.
- `cmd_valid` held high across two commands:
  - The second command is accepted exactly 1 cycle after `rsp_valid`.
  - No MDC edge occurs during the DONE/IDLE cycles.
- rstn pulsed low at bit 40 of a write:
  - mdc=0, mdio_oe=0 and cmd_ready=1 immediately.
  - No `rsp_valid`.
  - The next command produces a full, correct frame.
- With `MDIO_PREAMBLE_SUPPRESS_EN` and cmd_nopre=1, CLK_DIV=2: the frame starts with ST=01 and `rsp_valid` comes at cycle 129.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO management controller: FSM states,
// frame constants and per-state bit counts.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        HDR  = 3'd2,
        TA   = 3'd3,
        DATA = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [1:0] ST    = 2'b01;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;

    localparam int PRE_LEN  = 32;
    localparam int HDR_LEN  = 14;
    localparam int TA_LEN   = 2;
    localparam int DATA_LEN = 16;

    // Bit-counter reload on entry to a state: number of bits in that state minus one.
    function automatic logic [5:0] bit_reload(input state_t s);
        logic [5:0] r;
        r = 6'd0;
        case (s)
            PRE:     r = 6'(PRE_LEN - 1);
            HDR:     r = 6'(HDR_LEN - 1);
            TA:      r = 6'(TA_LEN - 1);
            DATA:    r = 6'(DATA_LEN - 1);
            default: r = 6'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: CLK_DIV-cycle low phase then CLK_DIV-cycle high phase, held low
// and reloaded whenever en is low so every frame starts on a fresh low phase.
module mdio_clk_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic mdc,
    output logic fall_stb,
    output logic rise_end_stb
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= RELOAD;
            mdc <= 1'b0;
        end else if (!en) begin
            cnt <= RELOAD;
            mdc <= 1'b0;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
            mdc <= ~mdc;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign rise_end_stb = en && mdc && (cnt == '0);
    // mdc drops on the edge that closes the last high cycle, so both strobes share it.
    assign fall_stb     = rise_end_stb;

endmodule

// File: rtl/mdio_master_ctrl.sv
// Clause-22 MDIO master: serialises one read/write command into a 64-bit frame.
// Optional preamble suppression is enabled with `define MDIO_PREAMBLE_SUPPRESS_EN.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// PRE   | 32 preamble ones
// HDR   | ST, OP, PHYAD, REGAD (14 bits)
// TA    | turnaround (write drives 10, read releases the line)
// DATA  | 16 data bits
// DONE  | one-cycle response strobe
module mdio_master_ctrl
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    input  logic        cmd_nopre,
`endif
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    state_t      state, state_d;
    logic [5:0]  bit_cnt;
    logic [31:0] sreg;
    logic        is_rd;
    logic        err_q;
    logic [14:0] rd_shift;
    logic [15:0] rdata_q;
    logic        accept;
    logic        nopre;
    logic        bit_last;
    logic        clk_en;
    logic        fall_stb;
    logic        rise_end_stb;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign nopre = cmd_nopre;
`else
    assign nopre = 1'b0;
`endif

    assign accept   = cmd_valid && (state == IDLE);
    assign bit_last = (bit_cnt == 6'd0);
    assign clk_en   = (state == PRE) || (state == HDR) || (state == TA) || (state == DATA);

    mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk          (clk),
        .rstn         (rstn),
        .en           (clk_en),
        .mdc          (mdc),
        .fall_stb     (fall_stb),
        .rise_end_stb (rise_end_stb)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            bit_cnt  <= 6'd0;
            sreg     <= '1;
            is_rd    <= 1'b0;
            err_q    <= 1'b0;
            rd_shift <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                // Read frames load ones into TA/DATA so the released line idles high.
                sreg    <= cmd_read ? {ST, OP_RD, cmd_phy, cmd_reg, 2'b11, 16'hFFFF}
                                    : {ST, OP_WR, cmd_phy, cmd_reg, 2'b10, cmd_wdata};
                is_rd   <= cmd_read;
                err_q   <= 1'b0;
                bit_cnt <= bit_reload(state_d);
            end else if (fall_stb) begin
                if (state != PRE) begin
                    sreg <= {sreg[30:0], 1'b1};
                end
                bit_cnt <= bit_last ? bit_reload(state_d) : bit_cnt - 6'd1;
            end
            if (rise_end_stb && is_rd) begin
                if ((state == TA) && bit_last) begin
                    err_q <= mdio_i;
                end
                if (state == DATA) begin
                    rd_shift <= {rd_shift[13:0], mdio_i};
                    if (bit_last) begin
                        rdata_q <= {rd_shift, mdio_i};
                    end
                end
            end
        end
    end

    always_comb begin
        state_d   = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        mdio_oe   = 1'b0;
        mdio_o    = sreg[31];
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (accept) state_d = nopre ? HDR : PRE;
            end
            PRE: begin
                mdio_oe = 1'b1;
                mdio_o  = 1'b1;
                if (fall_stb && bit_last) state_d = HDR;
            end
            HDR: begin
                mdio_oe = 1'b1;
                if (fall_stb && bit_last) state_d = TA;
            end
            TA: begin
                mdio_oe = !is_rd;
                if (fall_stb && bit_last) state_d = DATA;
            end
            DATA: begin
                mdio_oe = !is_rd;
                if (fall_stb && bit_last) state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = !cmd_ready;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Self-checking bench for mdio_master_ctrl with a behavioural PHY on the MDC/MDIO pins.
module tb_mdio_master_ctrl;

    localparam int CD = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [4:0]  cmd_phy;
    logic [4:0]  cmd_reg;
    logic [15:0] cmd_wdata;
    logic        cmd_nopre;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i = 1'b1;

    int errors = 0;
    int checks = 0;

    // PHY model state: every rising MDC edge is recorded as {oe, o}.
    logic [1:0]  cap_q[$];
    int          mdc_edges = 0;
    int          resp_base = 0;
    int          resp_off  = 0;
    logic [63:0] resp_vec  = '1;
    logic [15:0] model_rdata;

    typedef struct {
        logic        rd;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wd;
        logic        phy_on;
        logic        ta2;
        logic [15:0] pdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    mdio_master_ctrl #(.CLK_DIV(CD)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_read  (cmd_read),
        .cmd_phy   (cmd_phy),
        .cmd_reg   (cmd_reg),
        .cmd_wdata (cmd_wdata),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        .cmd_nopre (cmd_nopre),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mdc       (mdc),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .mdio_i    (mdio_i)
    );

    // The PHY changes mdio_i right after the rising edge; the master samples late in the high phase.
    always @(posedge mdc) begin
        int j;
        cap_q.push_back({mdio_oe, mdio_o});
        j = mdc_edges - resp_base + resp_off;
        if (j >= 0 && j < 64) mdio_i = resp_vec[63 - j];
        else                  mdio_i = 1'b1;
        mdc_edges = mdc_edges + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input string name, input logic rd, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] wd, input logic phy_on,
                           input logic ta2, input logic [15:0] pdata, input logic np,
                           input logic [15:0] exp_rdata, input logic exp_err);
        int n, off, nb, base, bad, j;
        logic [63:0] exp_vec;
        logic [1:0]  got;
        logic        exp_oe;
        off = np ? 32 : 0;
        nb  = 64 - off;
        exp_vec = {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), phy, rg,
                   (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : wd)};
        @(negedge clk);
        resp_vec  = phy_on ? {46'h3FFF_FFFF_FFFF, 1'b1, ta2, pdata} : '1;
        resp_off  = off;
        resp_base = mdc_edges;
        base      = cap_q.size();
        cmd_read  = rd;
        cmd_phy   = phy;
        cmd_reg   = rg;
        cmd_wdata = wd;
        cmd_nopre = np;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        chk({name, "_c1_mdc"}, 32'(mdc), 32'd0);
        chk({name, "_c1_oe"}, 32'(mdio_oe), 32'd1);
        chk({name, "_c1_o"}, 32'(mdio_o), np ? 32'd0 : 32'd1);
        chk({name, "_c1_busy"}, 32'(busy), 32'd1);
        while (!rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(nb * 2 * CD + 1));
        chk({name, "_err"}, 32'(rsp_err), 32'(exp_err));
        chk({name, "_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
        bad = 0;
        chk({name, "_nbits"}, 32'(cap_q.size() - base), 32'(nb));
        if (cap_q.size() - base == nb) begin
            for (int k = 0; k < nb; k++) begin
                j      = k + off;
                got    = cap_q[base + k];
                exp_oe = rd ? (j < 46) : 1'b1;
                if (got[1] !== exp_oe) bad++;
                else if (exp_oe && got[0] !== exp_vec[63 - j]) bad++;
            end
            chk({name, "_frame_bad_bits"}, 32'(bad), 32'd0);
        end
        @(negedge clk);
        chk({name, "_ready_after"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int n, e0, seen;
        logic        rd, phy_on, ta2, exp_err;
        logic [4:0]  phy, rg;
        logic [15:0] wd, pdata;

        tbl[0] = '{1'b0, 5'h01, 5'h00, 16'h1140, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{1'b1, 5'h01, 5'h02, 16'h0000, 1'b1, 1'b0, 16'h0022, 16'h0022, 1'b0};
        tbl[2] = '{1'b1, 5'h03, 5'h01, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
        tbl[3] = '{1'b0, 5'h1F, 5'h1F, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0};
        tbl[4] = '{1'b1, 5'h02, 5'h03, 16'h0000, 1'b1, 1'b1, 16'hA5A5, 16'hA5A5, 1'b1};

        rstn = 1'b0;
        cmd_valid = 1'b0;
        cmd_read = 1'b0;
        cmd_phy = '0;
        cmd_reg = '0;
        cmd_wdata = '0;
        cmd_nopre = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'h0);
        chk("rst_mdc", 32'(mdc), 32'd0);
        chk("rst_mdio_o", 32'(mdio_o), 32'd1);
        chk("rst_mdio_oe", 32'(mdio_oe), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_cmd($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].phy, tbl[i].rg, tbl[i].wd,
                    tbl[i].phy_on, tbl[i].ta2, tbl[i].pdata, 1'b0,
                    tbl[i].exp_rdata, tbl[i].exp_err);
        end
        model_rdata = 16'hA5A5;

        // cmd_valid held across two commands
        @(negedge clk);
        resp_vec = '1;
        resp_off = 0;
        resp_base = mdc_edges;
        cmd_read = 1'b0;
        cmd_phy = 5'h04;
        cmd_reg = 5'h05;
        cmd_wdata = 16'h1234;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        n = 1;
        while (!rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_latency", 32'(n), 32'(128 * CD + 1));
        chk("b2b_done_mdc", 32'(mdc), 32'd0);
        e0 = mdc_edges;
        @(negedge clk);
        chk("b2b_idle_ready", 32'(cmd_ready), 32'd1);
        chk("b2b_idle_mdc", 32'(mdc), 32'd0);
        @(negedge clk);
        chk("b2b_second_accepted", 32'(cmd_ready), 32'd0);
        chk("b2b_no_mdc_edge", 32'(mdc_edges - e0), 32'd0);
        cmd_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_second_latency", 32'(n), 32'(128 * CD + 1));
        chk("b2b_rdata_held", 32'(rsp_rdata), 32'(model_rdata));
        @(negedge clk);

        // reset pulse at bit 40 of a write
        cmd_read = 1'b0;
        cmd_phy = 5'h07;
        cmd_reg = 5'h09;
        cmd_wdata = 16'hC3C3;
        cmd_valid = 1'b1;
        e0 = mdc_edges;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while ((mdc_edges - e0) < 40 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached_bit40", 32'(mdc_edges - e0), 32'd40);
        rstn = 1'b0;
        #1;
        chk("mid_mdc", 32'(mdc), 32'd0);
        chk("mid_oe", 32'(mdio_oe), 32'd0);
        chk("mid_ready", 32'(cmd_ready), 32'd1);
        chk("mid_mdio_o", 32'(mdio_o), 32'd1);
        chk("mid_rdata", 32'(rsp_rdata), 32'h0);
        model_rdata = 16'h0000;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rstn = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("mid_no_rsp", 32'(seen), 32'd0);
        run_cmd("post_reset_wr", 1'b0, 5'h07, 5'h09, 16'hC3C3, 1'b0, 1'b0, 16'h0, 1'b0,
                model_rdata, 1'b0);

        // randomized commands against the behavioural model
        for (int i = 0; i < 6; i++) begin
            rd     = 1'($urandom_range(0, 1));
            phy    = 5'($urandom);
            rg     = 5'($urandom);
            wd     = 16'($urandom);
            phy_on = ($urandom_range(0, 3) != 0);
            ta2    = ($urandom_range(0, 3) == 0);
            pdata  = 16'($urandom);
            if (rd) begin
                model_rdata = phy_on ? pdata : 16'hFFFF;
                exp_err     = phy_on ? ta2 : 1'b1;
            end else begin
                exp_err = 1'b0;
            end
            run_cmd($sformatf("rnd%0d", i), rd, phy, rg, wd, phy_on, ta2, pdata, 1'b0,
                    model_rdata, exp_err);
        end

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        run_cmd("nopre_wr", 1'b0, 5'h01, 5'h00, 16'h1140, 1'b0, 1'b0, 16'h0, 1'b1,
                model_rdata, 1'b0);
        model_rdata = 16'h0022;
        run_cmd("nopre_rd", 1'b1, 5'h01, 5'h02, 16'h0, 1'b1, 1'b0, 16'h0022, 1'b1,
                model_rdata, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
